stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control unit for the stopwatch datapath. Conditions three raw push-buttons: start/stop, clear and lap. Runs the stopwatch mode state machine and produces the per-tick count enable, a clear pulse, and a display-freeze level. These outputs drive the enable/reset inputs of the digit counters and display registers. It is the command source that those flip-flop-based counters consume.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a button level is accepted (≥2)
- TICK_DIV, 4: clock cycles per count tick (≥2)

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- btn_start  in  1  raw start/stop button, asynchronous, active-high
- btn_clear  in  1  raw clear button, asynchronous, active-high
- btn_lap  in  1  raw lap button, asynchronous, active-high
- count_en  out  1  one-cycle pulse per tick while counting
- count_clr  out  1  one-cycle pulse commanding the counters to zero
- disp_hold  out  1  level; display registers frozen while high
- state  out  2  current mode: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

## Operation
- Button conditioner, identical per button:
  - 2-flop synchronizer.
  - Stability counter: increments while the synchronized input differs from the debounced level. It is cleared whenever they match. When it reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press pulse: registered rising edge of the debounced level, high one cycle. Release generates nothing.
- Same-cycle press priority: start > clear > lap. Lower-priority pulses in that cycle are discarded, not queued.
- FSM transitions (state is unchanged on any unlisted press):
  - IDLE: start → RUN. Clear → stay IDLE, count_clr pulse. Lap ignored.
  - RUN: start → PAUSE. Lap → LAP. Clear ignored.
  - LAP: lap → RUN. Start → PAUSE. Clear ignored.
  - PAUSE: start → RUN. Clear → IDLE with count_clr pulse. Lap ignored.
- disp_hold:
  - Is 1 exactly while state == LAP.
  - Leaving LAP by any path drops it with the state change.
- Prescaler, width clog2(TICK_DIV):
  - Counts 0..TICK_DIV-1 and wraps, only in RUN and LAP.
  - Holds its value in PAUSE, so resume continues the partial tick.
  - Forced to 0 in IDLE and on any count_clr.
- count_en: high for the one cycle in which the prescaler equals TICK_DIV-1 and state is RUN or LAP.
- All outputs are registered; no combinational path from buttons to outputs.

## Timing
- Reset (asynchronous assert, takes effect without a clock edge):
  - state=IDLE, count_en=0, count_clr=0, disp_hold=0.
  - Prescaler, synchronizers, stability counters and debounced levels all 0.
- Press latency:
  - Edge 0 is the first edge sampling a raw button held high steadily.
  - The press pulse is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - state, disp_hold and count_clr update at edge DEBOUNCE_CYCLES+3.
- count_clr is high for exactly the one cycle following the accepting edge.
- First count_en after entering RUN from IDLE: high in the TICK_DIV-th cycle after the state change. Thereafter one pulse every TICK_DIV cycles.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no press. Bounce restarts the stability count.
- A button held indefinitely produces exactly one press. A new press needs a debounced release first.
- Reset asserted mid-RUN: outputs clear immediately. After deassertion the block sits in IDLE with count_en=0 until a new start press.
- Presses arriving during reset are lost.

## Test plan
Use DEBOUNCE_CYCLES=4, TICK_DIV=5 unless stated.
- Reset then start held 20 cycles → state 01 at edge 7 after the first sampling edge. count_en pulses every 5 cycles, first one 5 cycles after the state change. Exactly one transition despite the hold.
- btn_start high 3 cycles, then low → no state change, count_en stays 0. Bounce pattern 1-0-1-1-0 followed by a steady 1 → single RUN transition.
- RUN → start after 7 cycles in RUN (prescaler=2) → PAUSE, no count_en. Start again → RUN, first count_en 3 cycles after resume.
- RUN → lap → state 11, disp_hold=1, count_en continues. Lap → state 01, disp_hold=0. Repeat, exiting LAP via start → state 10, disp_hold=0.
- PAUSE → clear → state 00, count_clr high exactly 1 cycle, prescaler 0. Clear in IDLE → count_clr pulse, state 00. Clear in RUN → ignored.
- start and clear pressed in the same cycle from PAUSE → RUN, no count_clr. Reset asserted asynchronously mid-LAP → all outputs 0 and state 00 before the next clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and command outputs of the stopwatch control unit.
// The master side drives raw buttons; the slave side is the controller.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_lap;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  modport master (
    output btn_start, btn_clear, btn_lap,
    input  count_en, count_clr, disp_hold, state
  );

  modport slave (
    input  btn_start, btn_clear, btn_lap,
    output count_en, count_clr, disp_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: debounces three buttons, runs the mode FSM and
// issues tick enables, clear pulses and the display-freeze level.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 4
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Bit 0 start, bit 1 clear, bit 2 lap.
  logic [2:0]    raw_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    deb_r;
  logic [2:0]    deb_d_r;
  logic [2:0]    press_r;
  logic [CW-1:0] stab_r [3];

  state_t        state_r;
  state_t        state_next;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_next;
  logic          clr_cmd;
  logic          running_next;
  logic          start_p;
  logic          clear_p;
  logic          lap_p;
  logic          count_en_r;
  logic          count_clr_r;
  logic          disp_hold_r;

  assign raw_s = {sw.btn_lap, sw.btn_clear, sw.btn_start};

  // Synchronize, debounce and edge-detect the three buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      deb_d_r <= 3'b000;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        stab_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_r & ~deb_d_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          stab_r[i] <= {CW{1'b0}};
        end else if (stab_r[i] == STAB_LAST) begin
          deb_r[i]  <= ~deb_r[i];
          stab_r[i] <= {CW{1'b0}};
        end else begin
          stab_r[i] <= stab_r[i] + CW'(1);
        end
      end
    end
  end

  // Same-cycle presses resolve start > clear > lap; losers are dropped.
  assign start_p = press_r[0];
  assign clear_p = press_r[1] & ~press_r[0];
  assign lap_p   = press_r[2] & ~press_r[1] & ~press_r[0];

  // Mode transitions, clear command and prescaler next value.
  always_comb begin
    state_next = state_r;
    clr_cmd    = 1'b0;
    presc_next = presc_r;
    case (state_r)
      IDLE: begin
        if (start_p) begin
          state_next = RUN;
        end else if (clear_p) begin
          clr_cmd = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (start_p) begin
          state_next = PAUSE;
        end else if (lap_p) begin
          state_next = LAP;
        end else begin
          state_next = RUN;
        end
      end
      LAP: begin
        if (lap_p) begin
          state_next = RUN;
        end else if (start_p) begin
          state_next = PAUSE;
        end else begin
          state_next = LAP;
        end
      end
      PAUSE: begin
        if (start_p) begin
          state_next = RUN;
        end else if (clear_p) begin
          state_next = IDLE;
          clr_cmd    = 1'b1;
        end else begin
          state_next = PAUSE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The prescaler advances on the current mode, so entering RUN starts at 0
    // and a pause keeps the partial tick for the resume.
    if (clr_cmd) begin
      presc_next = {PW{1'b0}};
    end else if (state_r == IDLE) begin
      presc_next = {PW{1'b0}};
    end else if ((state_r == RUN) || (state_r == LAP)) begin
      presc_next = (presc_r == PRE_LAST) ? {PW{1'b0}} : presc_r + PW'(1);
    end else begin
      presc_next = presc_r;
    end
  end

  assign running_next = (state_next == RUN) || (state_next == LAP);

  // Mode, prescaler and registered command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      presc_r     <= {PW{1'b0}};
      count_en_r  <= 1'b0;
      count_clr_r <= 1'b0;
      disp_hold_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      presc_r     <= presc_next;
      count_en_r  <= running_next && (presc_next == PRE_LAST);
      count_clr_r <= clr_cmd;
      disp_hold_r <= (state_next == LAP);
    end
  end

  assign sw.state     = state_r;
  assign sw.count_en  = count_en_r;
  assign sw.count_clr = count_clr_r;
  assign sw.disp_hold = disp_hold_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
module tb_stopwatch_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 5;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       sw.btn_start = v;
      1:       sw.btn_clear = v;
      default: sw.btn_lap   = v;
    endcase
  endtask

  // Hold a button through the accepting edge, then let go.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    step(DEB + 4);
    set_btn(idx, 1'b0);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b want %b", sw.state, ST_IDLE); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL reset_count_en: got %b want 0", sw.count_en); end
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL reset_count_clr: got %b want 0", sw.count_clr); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL reset_disp_hold: got %b want 0", sw.disp_hold); end
    step(2);
    reset = 1'b0;
    step(3);
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL post_reset_state: got %b want %b", sw.state, ST_IDLE); end
  endtask

  task automatic test_start_hold;
    int pulses;
    int bad;
    pulses = 0;
    bad    = 0;
    set_btn(0, 1'b1);
    step(DEB + 3);
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL hold_edge6_state: got %b want %b", sw.state, ST_IDLE); end
    step(1);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL hold_edge7_state: got %b want %b", sw.state, ST_RUN); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL hold_en_at_entry: got %b want 0", sw.count_en); end
    step(DIV - 2);
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL hold_en_early: got %b want 0", sw.count_en); end
    step(1);
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL hold_first_tick: got %b want 1", sw.count_en); end
    step(1);
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL hold_tick_width: got %b want 0", sw.count_en); end
    for (int i = 0; i < 22; i++) begin
      step(1);
      if (sw.count_en === 1'b1) pulses++;
      if (sw.state !== ST_RUN) bad++;
      if (i == 6) set_btn(0, 1'b0);
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL hold_tick_count: got %0d want 4", pulses); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_single_transition: left RUN %0d cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_run;
    int found;
    int bad;
    found = 0;
    bad   = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      step(1);
      if (sw.count_en === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL midrun_tick_seen: got %0d want 1", found); end
    #2;
    reset = 1'b1;
    sw.btn_start = 1'b1;
    #1;
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL midrun_async_state: got %b want %b", sw.state, ST_IDLE); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL midrun_async_en: got %b want 0", sw.count_en); end
    step(6);
    sw.btn_start = 1'b0;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if ((sw.state !== ST_IDLE) || (sw.count_en !== 1'b0)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrun_stays_idle: bad cycles %0d want 0", bad); end
  endtask

  task automatic test_glitch;
    int bad;
    bad = 0;
    set_btn(0, 1'b1);
    step(DEB - 1);
    set_btn(0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1);
      if ((sw.state !== ST_IDLE) || (sw.count_en !== 1'b0)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_rejected: bad cycles %0d want 0", bad); end
    // Bounce 1-0-1-1-0, then steady high.
    set_btn(0, 1'b1); step(1);
    set_btn(0, 1'b0); step(1);
    set_btn(0, 1'b1); step(2);
    set_btn(0, 1'b0); step(1);
    set_btn(0, 1'b1);
    step(DEB + 3);
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL bounce_not_early: got %b want %b", sw.state, ST_IDLE); end
    step(1);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL bounce_run: got %b want %b", sw.state, ST_RUN); end
    step(11);
    set_btn(0, 1'b0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (sw.state !== ST_RUN) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bounce_single: left RUN %0d cycles want 0", bad); end
  endtask

  task automatic test_pause;
    int bad;
    bad = 0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    press(0);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL pause_enter_run: got %b want %b", sw.state, ST_RUN); end
    step(9);
    set_btn(0, 1'b1);
    step(DEB + 3);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL pause_before: got %b want %b", sw.state, ST_RUN); end
    step(1);
    set_btn(0, 1'b0);
    checks++; if (sw.state !== ST_PAUSE) begin errors++; $display("FAIL pause_state: got %b want %b", sw.state, ST_PAUSE); end
    for (int i = 0; i < 10; i++) begin
      step(1);
      if ((sw.count_en !== 1'b0) || (sw.state !== ST_PAUSE)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_no_ticks: bad cycles %0d want 0", bad); end
    press(0);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL resume_state: got %b want %b", sw.state, ST_RUN); end
    step(1);
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL resume_en_c2: got %b want 0", sw.count_en); end
    step(1);
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL resume_en_c3: got %b want 1", sw.count_en); end
    step(1);
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL resume_en_c4: got %b want 0", sw.count_en); end
  endtask

  task automatic test_lap;
    step(5);
    set_btn(2, 1'b1);
    step(DEB + 3);
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL lap_hold_before: got %b want 0", sw.disp_hold); end
    step(1);
    set_btn(2, 1'b0);
    checks++; if (sw.state !== ST_LAP) begin errors++; $display("FAIL lap_state: got %b want %b", sw.state, ST_LAP); end
    checks++; if (sw.disp_hold !== 1'b1) begin errors++; $display("FAIL lap_hold: got %b want 1", sw.disp_hold); end
    step(1);
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL lap_ticks_continue: got %b want 1", sw.count_en); end
    step(7);
    set_btn(2, 1'b1);
    step(DEB + 3);
    checks++; if (sw.disp_hold !== 1'b1) begin errors++; $display("FAIL lap_exit_before: got %b want 1", sw.disp_hold); end
    step(1);
    set_btn(2, 1'b0);
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL lap_exit_state: got %b want %b", sw.state, ST_RUN); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL lap_exit_hold: got %b want 0", sw.disp_hold); end
    step(8);
    press(2);
    checks++; if (sw.state !== ST_LAP) begin errors++; $display("FAIL lap2_state: got %b want %b", sw.state, ST_LAP); end
    step(8);
    press(0);
    checks++; if (sw.state !== ST_PAUSE) begin errors++; $display("FAIL lap_start_state: got %b want %b", sw.state, ST_PAUSE); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL lap_start_hold: got %b want 0", sw.disp_hold); end
    step(8);
  endtask

  task automatic test_clear;
    set_btn(1, 1'b1);
    step(DEB + 3);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL clr_before: got %b want 0", sw.count_clr); end
    step(1);
    set_btn(1, 1'b0);
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL clr_pause_state: got %b want %b", sw.state, ST_IDLE); end
    checks++; if (sw.count_clr !== 1'b1) begin errors++; $display("FAIL clr_pause_pulse: got %b want 1", sw.count_clr); end
    step(1);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL clr_pause_width: got %b want 0", sw.count_clr); end
    step(7);
    press(1);
    checks++; if ((sw.state !== ST_IDLE) || (sw.count_clr !== 1'b1)) begin errors++; $display("FAIL clr_idle: state %b clr %b want 00 1", sw.state, sw.count_clr); end
    step(1);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL clr_idle_width: got %b want 0", sw.count_clr); end
    step(7);
    press(0);
    step(DIV - 2);
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL clr_presc_zero_early: got %b want 0", sw.count_en); end
    step(1);
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL clr_presc_zero_tick: got %b want 1", sw.count_en); end
    step(4);
    press(1);
    checks++; if ((sw.state !== ST_RUN) || (sw.count_clr !== 1'b0)) begin errors++; $display("FAIL clr_run_ignored: state %b clr %b want 01 0", sw.state, sw.count_clr); end
    step(1);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL clr_run_late: got %b want 0", sw.count_clr); end
  endtask

  task automatic test_same_cycle;
    step(7);
    press(0);
    checks++; if (sw.state !== ST_PAUSE) begin errors++; $display("FAIL same_setup: got %b want %b", sw.state, ST_PAUSE); end
    step(8);
    sw.btn_start = 1'b1;
    sw.btn_clear = 1'b1;
    step(DEB + 4);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    checks++; if (sw.state !== ST_RUN) begin errors++; $display("FAIL same_start_wins: got %b want %b", sw.state, ST_RUN); end
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL same_no_clr: got %b want 0", sw.count_clr); end
    step(1);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL same_no_clr_late: got %b want 0", sw.count_clr); end
    step(8);
  endtask

  task automatic test_reset_mid_lap;
    int found;
    found = 0;
    press(2);
    checks++; if ((sw.state !== ST_LAP) || (sw.disp_hold !== 1'b1)) begin errors++; $display("FAIL midlap_setup: state %b hold %b want 11 1", sw.state, sw.disp_hold); end
    for (int i = 0; i < 2 * DIV; i++) begin
      step(1);
      if (sw.count_en === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL midlap_tick_seen: got %0d want 1", found); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL midlap_state: got %b want %b", sw.state, ST_IDLE); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL midlap_hold: got %b want 0", sw.disp_hold); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL midlap_en: got %b want 0", sw.count_en); end
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL midlap_clr: got %b want 0", sw.count_clr); end
    step(2);
    reset = 1'b0;
    step(3);
    checks++; if (sw.state !== ST_IDLE) begin errors++; $display("FAIL midlap_after: got %b want %b", sw.state, ST_IDLE); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap   = 1'b0;
    test_reset();
    test_start_hold();
    test_reset_mid_run();
    test_glitch();
    test_pause();
    test_lap();
    test_clear();
    test_same_cycle();
    test_reset_mid_lap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
